// File: rtl/om_write_arbiter_pkg.sv
// Shared constants, requester identities and arbiter state for the board
// object-memory write path.
package squares_pkg;

  localparam int OM_ADDR_W = 7;
  localparam int OM_DATA_W = 11;
  localparam int OM_DEPTH  = 105;
  localparam int NUM_REQ   = 3;

  localparam logic [1:0] REQ_NEWGAME = 2'd0;
  localparam logic [1:0] REQ_MOVE    = 2'd1;
  localparam logic [1:0] REQ_CURSOR  = 2'd2;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = REQ_NEWGAME;
    if (oh[REQ_MOVE]) begin
      idx = REQ_MOVE;
    end else if (oh[REQ_CURSOR]) begin
      idx = REQ_CURSOR;
    end
    return idx;
  endfunction

endpackage

// File: rtl/om_write_arbiter_if.sv
// Requester/arbiter bundle: ownership requests, per-requester write lanes and
// the registered object-memory write port.
interface om_write_arbiter_if;
  import squares_pkg::*;

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0]           wr_valid;
  logic [NUM_REQ*OM_ADDR_W-1:0] wr_addr;
  logic [NUM_REQ*OM_DATA_W-1:0] wr_data;
  logic [NUM_REQ-1:0]           grant;
  logic [OM_ADDR_W-1:0]         address_write_om;
  logic [OM_DATA_W-1:0]         data_write_om;
  logic                         wren;
  logic                         busy;
  logic                         drop_error;

  modport master (
    output req, wr_valid, wr_addr, wr_data,
    input  grant, address_write_om, data_write_om, wren, busy, drop_error
  );

  modport slave (
    input  req, wr_valid, wr_addr, wr_data,
    output grant, address_write_om, data_write_om, wren, busy, drop_error
  );

endinterface

// File: rtl/om_write_arbiter_grant_select.sv
// Combinational choice of the next owner: the new-game loader always wins,
// otherwise move engine and cursor updater alternate on a tie.
module om_grant_select
  import squares_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_rrLast,
  output logic [NUM_REQ-1:0] o_nextOwner
);

  always_comb begin
    o_nextOwner = '0;
    if (i_req[REQ_NEWGAME]) begin
      o_nextOwner[REQ_NEWGAME] = 1'b1;
    end else if (i_req[REQ_MOVE] && i_req[REQ_CURSOR]) begin
      // On a tie the requester that was not served last goes next.
      if (i_rrLast == REQ_MOVE) begin
        o_nextOwner[REQ_CURSOR] = 1'b1;
      end else begin
        o_nextOwner[REQ_MOVE] = 1'b1;
      end
    end else if (i_req[REQ_MOVE]) begin
      o_nextOwner[REQ_MOVE] = 1'b1;
    end else if (i_req[REQ_CURSOR]) begin
      o_nextOwner[REQ_CURSOR] = 1'b1;
    end
  end

endmodule

// File: rtl/om_write_arbiter.sv
// Owns the single object-memory write port and hands it to one requester at
// a time; the owner's strobes are range-checked and registered onto the port.
module om_write_arbiter
  import squares_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic          clk,
  input logic          reset,
  om_write_arbiter_if.slave bus
);

  localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t           r_state;
  arb_state_t           w_stateNext;
  logic [1:0]           r_owner;
  logic [1:0]           w_ownerNext;
  logic [1:0]           r_rrLast;
  logic [1:0]           w_rrLastNext;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   w_grantNext;
  logic [HOLD_W-1:0]    r_holdCnt;
  logic [HOLD_W-1:0]    w_holdNext;

  logic [NUM_REQ-1:0]   w_select;
  logic [NUM_REQ-1:0]   w_ownerMask;
  logic [NUM_REQ-1:0]   w_others;
  logic                 w_ownerReq;
  logic                 w_accept;
  logic                 w_inRange;
  logic [OM_ADDR_W-1:0] w_addr;
  logic [OM_DATA_W-1:0] w_data;

  logic                 r_wren;
  logic                 r_drop;
  logic                 r_busy;
  logic [OM_ADDR_W-1:0] r_addr;
  logic [OM_DATA_W-1:0] r_data;

  om_grant_select u_grantSelect (
    .i_req       (bus.req),
    .i_rrLast    (r_rrLast),
    .o_nextOwner (w_select)
  );

  // Owner-lane mux; an owner index outside 0..2 selects nothing.
  always_comb begin
    w_ownerMask = '0;
    w_addr      = '0;
    w_data      = '0;
    case (r_owner)
      REQ_NEWGAME: begin
        w_ownerMask = 3'b001;
        w_addr      = bus.wr_addr[0*OM_ADDR_W +: OM_ADDR_W];
        w_data      = bus.wr_data[0*OM_DATA_W +: OM_DATA_W];
      end
      REQ_MOVE: begin
        w_ownerMask = 3'b010;
        w_addr      = bus.wr_addr[1*OM_ADDR_W +: OM_ADDR_W];
        w_data      = bus.wr_data[1*OM_DATA_W +: OM_DATA_W];
      end
      REQ_CURSOR: begin
        w_ownerMask = 3'b100;
        w_addr      = bus.wr_addr[2*OM_ADDR_W +: OM_ADDR_W];
        w_data      = bus.wr_data[2*OM_DATA_W +: OM_DATA_W];
      end
      default: begin
        w_ownerMask = '0;
      end
    endcase
    w_ownerReq = |(bus.req & w_ownerMask);
    w_others   = bus.req & ~w_ownerMask;
    w_accept   = |(r_grant & bus.wr_valid & w_ownerMask);
    w_inRange  = (w_addr < OM_ADDR_W'(OM_DEPTH));
  end

  always_comb begin
    w_stateNext  = r_state;
    w_ownerNext  = r_owner;
    w_grantNext  = r_grant;
    w_holdNext   = r_holdCnt;
    w_rrLastNext = r_rrLast;
    case (r_state)
      ARB_IDLE: begin
        w_grantNext = '0;
        w_holdNext  = '0;
        if (|bus.req) begin
          w_stateNext = ARB_OWNED;
          w_grantNext = w_select;
          w_ownerNext = onehot_to_idx(w_select);
          if (!w_select[REQ_NEWGAME]) begin
            w_rrLastNext = onehot_to_idx(w_select);
          end
        end
      end
      ARB_OWNED: begin
        if ((w_ownerMask == '0) || !w_ownerReq) begin
          w_stateNext = ARB_IDLE;
          w_grantNext = '0;
          w_holdNext  = '0;
        end else if (r_owner != REQ_NEWGAME) begin
          // Counter saturates on the last allowed cycle; revoke only if contended.
          if (r_holdCnt == HOLD_LAST) begin
            if (|w_others) begin
              w_stateNext = ARB_IDLE;
              w_grantNext = '0;
              w_holdNext  = '0;
            end
          end else begin
            w_holdNext = r_holdCnt + 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = ARB_IDLE;
        w_grantNext = '0;
        w_holdNext  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ARB_IDLE;
      r_owner   <= REQ_NEWGAME;
      r_grant   <= '0;
      r_holdCnt <= '0;
      r_rrLast  <= REQ_CURSOR;
      r_busy    <= 1'b0;
      r_wren    <= 1'b0;
      r_drop    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_owner   <= w_ownerNext;
      r_grant   <= w_grantNext;
      r_holdCnt <= w_holdNext;
      r_rrLast  <= w_rrLastNext;
      r_busy    <= |w_grantNext;
      r_wren    <= w_accept && w_inRange;
      r_drop    <= w_accept && !w_inRange;
      if (w_accept && w_inRange) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  end

  assign bus.grant            = r_grant;
  assign bus.busy             = r_busy;
  assign bus.wren             = r_wren;
  assign bus.drop_error       = r_drop;
  assign bus.address_write_om = r_addr;
  assign bus.data_write_om    = r_data;

endmodule

// File: tb/tb_om_write_arbiter.sv
// Bench for om_write_arbiter: directed scenarios and randomized traffic, all
// compared against a tenure-counting reference model of the ownership rules.
module tb_om_write_arbiter;
  import squares_pkg::*;

  localparam int MAX_HOLD = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  om_write_arbiter_if bus ();

  om_write_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  int                   mOwner  = -1;
  int                   mTenure = 0;
  int                   mLastRr = 2;
  logic [2:0]           mGrant  = 3'b000;
  logic                 mBusy   = 1'b0;
  logic                 mWren   = 1'b0;
  logic                 mDrop   = 1'b0;
  logic [OM_ADDR_W-1:0] mAddr   = '0;
  logic [OM_DATA_W-1:0] mData   = '0;

  // Reference model: owner as an integer, tenure as cycles owned so far.
  always @(posedge clk) begin : model
    int   a;
    logic pending;
    if (reset) begin
      mOwner = -1; mTenure = 0; mLastRr = 2;
      mWren = 1'b0; mDrop = 1'b0; mAddr = '0; mData = '0;
    end else begin
      mWren = 1'b0;
      mDrop = 1'b0;
      if (mOwner >= 0 && bus.wr_valid[mOwner]) begin
        a = int'(bus.wr_addr[mOwner*OM_ADDR_W +: OM_ADDR_W]);
        if (a < OM_DEPTH) begin
          mWren = 1'b1;
          mAddr = a[OM_ADDR_W-1:0];
          mData = bus.wr_data[mOwner*OM_DATA_W +: OM_DATA_W];
        end else begin
          mDrop = 1'b1;
        end
      end
      if (mOwner < 0) begin
        if (bus.req[0])                    mOwner = 0;
        else if (bus.req[1] && bus.req[2]) mOwner = 3 - mLastRr;
        else if (bus.req[1])               mOwner = 1;
        else if (bus.req[2])               mOwner = 2;
        if (mOwner > 0) mLastRr = mOwner;
        mTenure = 0;
      end else if (!bus.req[mOwner]) begin
        mOwner = -1;
      end else if (mOwner != 0) begin
        mTenure++;
        pending = |(bus.req & ~(3'b001 << mOwner));
        if (mTenure >= MAX_HOLD && pending) mOwner = -1;
      end
    end
    mGrant = (mOwner < 0) ? 3'b000 : 3'(1 << mOwner);
    mBusy  = (mOwner >= 0);
  end

  task automatic driveWrite(input logic [2:0] req, input int who, input int addr, input int data);
    bus.req      = req;
    bus.wr_valid = '0;
    if (who >= 0) begin
      bus.wr_valid[who] = 1'b1;
      bus.wr_addr[who*OM_ADDR_W +: OM_ADDR_W] = OM_ADDR_W'(addr);
      bus.wr_data[who*OM_DATA_W +: OM_DATA_W] = OM_DATA_W'(data);
    end
  endtask

  task automatic test_reset();
    driveWrite(3'b001, -1, 0, 0);
    @(negedge clk);
    driveWrite(3'b001, 0, 5, 7);
    @(negedge clk);
    checkCount++;
    if ({bus.grant, bus.busy, bus.wren, bus.address_write_om, bus.data_write_om} !==
        {3'b001, 1'b1, 1'b1, 7'd5, 11'd7}) begin
      failCount++;
      $display("[TB] FAIL reset_preload got gnt=%b busy=%b wren=%b addr=%0d data=%0d want 001/1/1/5/7",
               bus.grant, bus.busy, bus.wren, bus.address_write_om, bus.data_write_om);
    end else passCount++;
    reset = 1'b1;
    driveWrite(3'b001, 0, 110, 1);
    @(negedge clk);
    reset = 1'b0;
    driveWrite(3'b000, -1, 0, 0);
    checkCount++;
    if ({bus.grant, bus.busy, bus.wren, bus.drop_error, bus.address_write_om, bus.data_write_om} !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_clear got gnt=%b busy=%b wren=%b drop=%b addr=%0d data=%0d want all zero",
               bus.grant, bus.busy, bus.wren, bus.drop_error, bus.address_write_om, bus.data_write_om);
    end else passCount++;
    @(negedge clk);
    checkCount++;
    if ({bus.grant, bus.busy} !== {mGrant, mBusy}) begin
      failCount++;
      $display("[TB] FAIL reset_idle got gnt=%b busy=%b want gnt=%b busy=%b", bus.grant, bus.busy, mGrant, mBusy);
    end else passCount++;
  endtask

  task automatic test_newgame_burst();
    int seen = 0;
    driveWrite(3'b001, -1, 0, 0);
    @(negedge clk);
    checkCount++;
    if (bus.grant !== 3'b001) begin
      failCount++;
      $display("[TB] FAIL burst_grant got %b want 001", bus.grant);
    end else passCount++;
    for (int i = 0; i <= OM_DEPTH; i++) begin
      if (i < OM_DEPTH) driveWrite(3'b001, 0, i, i);
      else              driveWrite(3'b000, -1, 0, 0);
      @(negedge clk);
      if (bus.wren === 1'b1) seen++;
      checkCount++;
      if (i < OM_DEPTH) begin
        if ({bus.wren, bus.address_write_om, bus.data_write_om} !== {1'b1, 7'(i), 11'(i)}) begin
          failCount++;
          $display("[TB] FAIL burst_write%0d got wren=%b addr=%0d data=%0d want 1/%0d/%0d",
                   i, bus.wren, bus.address_write_om, bus.data_write_om, i, i);
        end else passCount++;
      end else begin
        if ({bus.grant, bus.wren} !== {3'b000, 1'b0}) begin
          failCount++;
          $display("[TB] FAIL burst_release got gnt=%b wren=%b want 000/0", bus.grant, bus.wren);
        end else passCount++;
      end
      checkCount++;
      if ({bus.grant, bus.busy, bus.wren, bus.drop_error} !== {mGrant, mBusy, mWren, mDrop}) begin
        failCount++;
        $display("[TB] FAIL burst_model got %b/%b/%b/%b want %b/%b/%b/%b", bus.grant, bus.busy, bus.wren,
                 bus.drop_error, mGrant, mBusy, mWren, mDrop);
      end else passCount++;
    end
    checkCount++;
    if (seen !== OM_DEPTH) begin
      failCount++;
      $display("[TB] FAIL burst_count got %0d wren pulses want %0d", seen, OM_DEPTH);
    end else passCount++;
  endtask

  task automatic test_priority();
    driveWrite(3'b111, -1, 0, 0);
    for (int k = 0; k < 53; k++) begin
      if (k == 50) bus.req = 3'b110;
      if (k == 52) bus.req = 3'b000;
      @(negedge clk);
      checkCount++;
      if (k < 50 && bus.grant !== 3'b001) begin
        failCount++;
        $display("[TB] FAIL priority_hold%0d got %b want 001", k, bus.grant);
      end else if (k == 50 && bus.grant !== 3'b000) begin
        failCount++;
        $display("[TB] FAIL priority_bubble got %b want 000", bus.grant);
      end else if (k == 51 && bus.grant !== 3'b010) begin
        failCount++;
        $display("[TB] FAIL priority_next got %b want 010", bus.grant);
      end else passCount++;
      checkCount++;
      if ({bus.grant, bus.busy, bus.wren, bus.drop_error} !== {mGrant, mBusy, mWren, mDrop}) begin
        failCount++;
        $display("[TB] FAIL priority_model got %b/%b/%b/%b want %b/%b/%b/%b", bus.grant, bus.busy, bus.wren,
                 bus.drop_error, mGrant, mBusy, mWren, mDrop);
      end else passCount++;
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] expG;
    reset = 1'b1;
    driveWrite(3'b000, -1, 0, 0);
    @(negedge clk);
    reset   = 1'b0;
    bus.req = 3'b110;
    for (int k = 0; k < 76; k++) begin
      if (k == 35) bus.req = 3'b010;
      if (k == 75) bus.req = 3'b000;
      @(negedge clk);
      if (k < 16)       expG = 3'b010;
      else if (k == 16) expG = 3'b000;
      else if (k < 33)  expG = 3'b100;
      else if (k == 33) expG = 3'b000;
      else if (k < 75)  expG = 3'b010;
      else              expG = 3'b000;
      checkCount++;
      if (bus.grant !== expG) begin
        failCount++;
        $display("[TB] FAIL rr_seq%0d got %b want %b", k, bus.grant, expG);
      end else passCount++;
      checkCount++;
      if ({bus.grant, bus.busy, bus.wren, bus.drop_error} !== {mGrant, mBusy, mWren, mDrop}) begin
        failCount++;
        $display("[TB] FAIL rr_model got %b/%b/%b/%b want %b/%b/%b/%b", bus.grant, bus.busy, bus.wren,
                 bus.drop_error, mGrant, mBusy, mWren, mDrop);
      end else passCount++;
    end
  endtask

  task automatic test_range();
    int addrs[3] = '{105, 127, 104};
    int datas[3] = '{2047, 291, 1445};
    driveWrite(3'b100, -1, 0, 0);
    @(negedge clk);
    checkCount++;
    if (bus.grant !== 3'b100) begin
      failCount++;
      $display("[TB] FAIL range_grant got %b want 100", bus.grant);
    end else passCount++;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) driveWrite(3'b100, 2, addrs[k], datas[k]);
      else       driveWrite(3'b100, -1, 0, 0);
      @(negedge clk);
      checkCount++;
      if (k < 2 && {bus.wren, bus.drop_error} !== 2'b01) begin
        failCount++;
        $display("[TB] FAIL range_drop%0d got wren=%b drop=%b want 0/1", k, bus.wren, bus.drop_error);
      end else if (k == 2 && {bus.wren, bus.drop_error, bus.address_write_om, bus.data_write_om} !==
                   {2'b10, 7'd104, 11'd1445}) begin
        failCount++;
        $display("[TB] FAIL range_last got wren=%b drop=%b addr=%0d data=%0d want 1/0/104/1445",
                 bus.wren, bus.drop_error, bus.address_write_om, bus.data_write_om);
      end else if (k == 3 && {bus.wren, bus.drop_error} !== 2'b00) begin
        failCount++;
        $display("[TB] FAIL range_quiet got wren=%b drop=%b want 0/0", bus.wren, bus.drop_error);
      end else passCount++;
    end
    driveWrite(3'b000, -1, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_ignored_and_reset();
    driveWrite(3'b010, -1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      case (k)
        1: driveWrite(3'b010, 2, 3, 9);
        2: driveWrite(3'b010, 2, 120, 0);
        3: driveWrite(3'b100, -1, 0, 0);
        5: driveWrite(3'b100, 2, 10, 20);
        6: begin reset = 1'b1; driveWrite(3'b100, 2, 11, 21); end
        7: begin reset = 1'b0; driveWrite(3'b110, -1, 0, 0); end
        default: ;
      endcase
      @(negedge clk);
      checkCount++;
      if ((k == 2 || k == 3) && {bus.wren, bus.drop_error} !== 2'b00) begin
        failCount++;
        $display("[TB] FAIL ignore_strobe%0d got wren=%b drop=%b want 0/0", k, bus.wren, bus.drop_error);
      end else if (k == 6 && {bus.grant, bus.wren, bus.busy} !== 5'b0) begin
        failCount++;
        $display("[TB] FAIL midburst_reset got gnt=%b wren=%b busy=%b want 000/0/0", bus.grant, bus.wren, bus.busy);
      end else if (k == 7 && bus.grant !== 3'b010) begin
        failCount++;
        $display("[TB] FAIL post_reset_tie got %b want 010", bus.grant);
      end else passCount++;
      checkCount++;
      if ({bus.grant, bus.busy, bus.wren, bus.drop_error} !== {mGrant, mBusy, mWren, mDrop}) begin
        failCount++;
        $display("[TB] FAIL ignore_model%0d got %b/%b/%b/%b want %b/%b/%b/%b", k, bus.grant, bus.busy,
                 bus.wren, bus.drop_error, mGrant, mBusy, mWren, mDrop);
      end else passCount++;
    end
    driveWrite(3'b000, -1, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0] r = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      if (r[0] && $urandom_range(0, 3) == 0) r[0] = 1'b0;
      bus.req      = r;
      bus.wr_valid = 3'($urandom);
      bus.wr_addr  = 21'($urandom);
      bus.wr_data  = 33'({$urandom, $urandom});
      reset        = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      checkCount++;
      if ({bus.grant, bus.busy, bus.wren, bus.drop_error} !== {mGrant, mBusy, mWren, mDrop}) begin
        failCount++;
        $display("[TB] FAIL random_model%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, bus.grant, bus.busy,
                 bus.wren, bus.drop_error, mGrant, mBusy, mWren, mDrop);
      end else passCount++;
      if (mWren) begin
        checkCount++;
        if ({bus.address_write_om, bus.data_write_om} !== {mAddr, mData}) begin
          failCount++;
          $display("[TB] FAIL random_wdata%0d got %0d/%0d want %0d/%0d", c, bus.address_write_om,
                   bus.data_write_om, mAddr, mData);
        end else passCount++;
      end
    end
    reset = 1'b0;
    driveWrite(3'b000, -1, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    bus.req      = '0;
    bus.wr_valid = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    reset        = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_newgame_burst();
    test_priority();
    test_round_robin();
    test_range();
    test_ignored_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
